// File: rtl/osd_spi_pkg.sv
// osd_spi_pkg: opcodes, ACK signature byte and FSM state type shared by the
// osd_spi_master block and its testbench.
package osd_spi_pkg;

  // Opcodes understood by the OSD/config/data-pump SPI slave
  localparam logic [7:0] OP_ACK     = 8'h00;
  localparam logic [7:0] OP_RDDATA  = 8'h10;
  localparam logic [7:0] OP_RDCONF  = 8'h14;
  localparam logic [7:0] OP_OSDWR   = 8'h20;
  localparam logic [7:0] OP_OSDDIS  = 8'h40;
  localparam logic [7:0] OP_OSDEN   = 8'h41;
  localparam logic [7:0] OP_CONF    = 8'h60;
  localparam logic [7:0] OP_PUMP    = 8'h61;
  localparam logic [7:0] OP_PUMPEND = 8'h62;

  // Byte the slave returns as the first payload byte of an ACK command
  localparam logic [7:0] ACK_BYTE   = 8'h4B;

  // HOLD keeps sck low for one half-bit after the last falling edge
  // before ss is released
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_STALL,
    ST_HOLD,
    ST_GAP
  } state_t;

endpackage

// File: rtl/osd_spi_bitshift.sv
// osd_spi_bitshift: sck divider plus 8-bit mosi/miso shift registers.
// byte_load arms a new byte (sck low, divider cleared); shifting advances
// only while run is high. byte_done is high in the cycle whose closing clk
// edge produces the byte's final sck falling edge, so a byte_load issued in
// that same cycle continues without any gap.
module osd_spi_bitshift #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       run,
  input  logic       byte_load,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       byte_done,
  output logic [7:0] rx_byte
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt_reg;
  logic [7:0] tx_shift_reg;
  logic [7:0] rx_shift_reg;
  logic [2:0] bit_cnt_reg;
  logic       sck_reg;
  logic       active_reg;
  logic       div_wrap;

  assign div_wrap  = run && active_reg && (div_cnt_reg == DIV_LAST);
  assign byte_done = div_wrap && sck_reg && (bit_cnt_reg == 3'd7);

  assign sck     = sck_reg;
  assign mosi    = tx_shift_reg[7];
  assign rx_byte = rx_shift_reg;

  // Half-bit divider, sck toggling, miso capture on rise, mosi shift on fall
  always_ff @(posedge clk) begin
    if (srst) begin
      div_cnt_reg  <= 8'd0;
      tx_shift_reg <= 8'd0;
      rx_shift_reg <= 8'd0;
      bit_cnt_reg  <= 3'd0;
      sck_reg      <= 1'b0;
      active_reg   <= 1'b0;
    end else if (byte_load) begin
      tx_shift_reg <= tx_byte;
      bit_cnt_reg  <= 3'd0;
      div_cnt_reg  <= 8'd0;
      sck_reg      <= 1'b0;
      active_reg   <= 1'b1;
    end else if (run && active_reg) begin
      if (div_wrap) begin
        div_cnt_reg <= 8'd0;
        if (!sck_reg) begin
          sck_reg      <= 1'b1;
          rx_shift_reg <= {rx_shift_reg[6:0], miso};
        end else begin
          sck_reg <= 1'b0;
          if (bit_cnt_reg == 3'd7) begin
            // Last bit stays on mosi until the next byte is loaded
            active_reg <= 1'b0;
          end else begin
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
          end
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + 8'd1;
      end
    end
  end

endmodule

// File: rtl/osd_spi_master.sv
// osd_spi_master: mode-0 SPI master issuing one opcode + cmd_len payload
// bytes per command. Payload bytes stream in over tx_valid/tx_ready and
// every MISO byte after the opcode is returned on rx_valid.
// Optional build macro OSD_SPI_ACK_CHECK_EN enables the ACK-byte check that
// drives ack_ok/ack_err; without it both outputs are tied low.
module osd_spi_master
  import osd_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SS_SETUP = 2,
  parameter int SS_GAP   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [15:0] cmd_len,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        spi_sck,
  output logic        spi_ss,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        ack_ok,
  output logic        ack_err
);

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(SS_SETUP - 1);
  localparam logic [7:0] GAP_LAST   = 8'(SS_GAP - 1);

  state_t      state_reg;
  logic [7:0]  cnt_reg;
  logic [16:0] total_reg;     // 1 + cmd_len bytes on the wire
  logic [16:0] byte_cnt_reg;  // bytes fully shifted so far
  logic        ss_reg;
  logic        busy_reg;
  logic        cmd_ready_reg;
  logic        rx_valid_reg;
  logic [7:0]  rx_data_reg;

  logic        accept;
  logic        last_byte;
  logic        run;
  logic        byte_load;
  logic        tx_take;
  logic [7:0]  load_byte;
  logic        byte_done;
  logic [7:0]  rx_byte;

  assign accept    = (state_reg == ST_IDLE) && cmd_valid && cmd_ready_reg;
  assign last_byte = ((byte_cnt_reg + 17'd1) == total_reg);
  assign run       = (state_reg == ST_SHIFT);

  // Choose what the shifter loads: opcode at accept, payload on handshake
  always_comb begin
    byte_load = 1'b0;
    tx_take   = 1'b0;
    load_byte = tx_data;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          byte_load = 1'b1;
          load_byte = cmd_op;
        end
      end
      ST_SHIFT: begin
        if (byte_done && !last_byte && tx_valid) begin
          byte_load = 1'b1;
          tx_take   = 1'b1;
        end
      end
      ST_STALL: begin
        if (tx_valid) begin
          byte_load = 1'b1;
          tx_take   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  osd_spi_bitshift #(
    .CLK_DIV (CLK_DIV)
  ) u_bitshift (
    .clk       (clk),
    .srst      (reset),
    .run       (run),
    .byte_load (byte_load),
    .tx_byte   (load_byte),
    .miso      (spi_miso),
    .sck       (spi_sck),
    .mosi      (spi_mosi),
    .byte_done (byte_done),
    .rx_byte   (rx_byte)
  );

  // Transaction FSM: ss framing, byte accounting, rx strobe, busy/ready
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 8'd0;
      total_reg     <= 17'd0;
      byte_cnt_reg  <= 17'd0;
      ss_reg        <= 1'b1;
      busy_reg      <= 1'b0;
      cmd_ready_reg <= 1'b1;
      rx_valid_reg  <= 1'b0;
      rx_data_reg   <= 8'd0;
    end else begin
      rx_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            total_reg     <= {1'b0, cmd_len} + 17'd1;
            byte_cnt_reg  <= 17'd0;
            ss_reg        <= 1'b0;
            busy_reg      <= 1'b1;
            cmd_ready_reg <= 1'b0;
            cnt_reg       <= 8'd0;
            state_reg     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_reg == SETUP_LAST) begin
            cnt_reg   <= 8'd0;
            state_reg <= ST_SHIFT;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        ST_SHIFT: begin
          if (byte_done) begin
            byte_cnt_reg <= byte_cnt_reg + 17'd1;
            // Byte 0 is the opcode; its MISO bits are dropped
            if (byte_cnt_reg != 17'd0) begin
              rx_valid_reg <= 1'b1;
              rx_data_reg  <= rx_byte;
            end
            if (last_byte) begin
              cnt_reg   <= 8'd0;
              state_reg <= ST_HOLD;
            end else if (!tx_valid) begin
              state_reg <= ST_STALL;
            end
          end
        end
        ST_STALL: begin
          if (tx_valid) begin
            state_reg <= ST_SHIFT;
          end
        end
        ST_HOLD: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg   <= 8'd0;
            ss_reg    <= 1'b1;
            state_reg <= ST_GAP;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        ST_GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg       <= 8'd0;
            busy_reg      <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign busy      = busy_reg;
  assign spi_ss    = ss_reg;
  assign tx_ready  = tx_take;
  assign rx_valid  = rx_valid_reg;
  assign rx_data   = rx_data_reg;

`ifdef OSD_SPI_ACK_CHECK_EN
  logic [7:0] op_reg;
  logic       ack_ok_reg;
  logic       ack_err_reg;
  logic       ack_check;

  // First payload byte of an ACK command, evaluated when it completes
  assign ack_check = (state_reg == ST_SHIFT) && byte_done &&
                     (byte_cnt_reg == 17'd1) && (op_reg == OP_ACK);

  // Latch the opcode and flag the ACK result alongside that byte's rx_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg      <= 8'd0;
      ack_ok_reg  <= 1'b0;
      ack_err_reg <= 1'b0;
    end else begin
      if (accept) begin
        op_reg <= cmd_op;
      end
      ack_ok_reg  <= ack_check && (rx_byte == ACK_BYTE);
      ack_err_reg <= ack_check && (rx_byte != ACK_BYTE);
    end
  end

  assign ack_ok  = ack_ok_reg;
  assign ack_err = ack_err_reg;
`else
  assign ack_ok  = 1'b0;
  assign ack_err = 1'b0;
`endif

endmodule

// File: tb/tb_osd_spi_master.sv
// tb_osd_spi_master: table-driven transactions against a bench-side SPI
// slave model; expected mosi bytes and rx bytes are queued when a command is
// issued and popped as the slave / rx_valid produce them.
module tb_osd_spi_master;
  import osd_spi_pkg::*;

  localparam int CLK_DIV  = 2;
  localparam int SS_SETUP = 2;
  localparam int SS_GAP   = 4;
  localparam int STALL_N  = 16 * CLK_DIV + 10;
`ifdef OSD_SPI_ACK_CHECK_EN
  localparam int ACK_EN = 1;
`else
  localparam int ACK_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_op = 8'h00;
  logic [15:0] cmd_len = 16'h0000;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        busy;
  logic        spi_sck;
  logic        spi_ss;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  logic        ack_ok;
  logic        ack_err;

  always #5 clk = ~clk;

  osd_spi_master #(
    .CLK_DIV (CLK_DIV),
    .SS_SETUP(SS_SETUP),
    .SS_GAP  (SS_GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_len  (cmd_len),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .ack_ok   (ack_ok),
    .ack_err  (ack_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard queues
  logic [7:0] exp_mosi_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] slave_q[$];

  // Monitor / slave-model state (owned by the monitor process)
  int n_rise = 0, n_rxv = 0, n_txr = 0, n_ackok = 0, n_ackerr = 0;
  int first_rise = -1, last_fall = 0, ss_fall_cyc = 0, ss_rise_cyc = 0;
  int s_rcnt = 0, s_bit = 0;
  logic prev_sck = 1'b0, prev_ss = 1'b1;
  logic [7:0] s_in = 8'h00, s_out = 8'h00;

  function automatic logic [7:0] pop_slave();
    if (slave_q.size() == 0) return 8'h00;
    return slave_q.pop_front();
  endfunction

  // Slave model and output monitor, sampled on the falling clk edge
  always @(negedge clk) begin
    if (prev_ss && !spi_ss) begin
      s_rcnt = 0;
      s_bit = 0;
      s_out = pop_slave();
      spi_miso = s_out[7];
      ss_fall_cyc = cyc;
      first_rise = -1;
    end
    if (!prev_ss && spi_ss) ss_rise_cyc = cyc;
    if (!spi_ss && !prev_sck && spi_sck) begin
      n_rise++;
      if (first_rise < 0) first_rise = cyc;
      s_in = {s_in[6:0], spi_mosi};
      s_rcnt++;
      if (s_rcnt == 8) begin
        s_rcnt = 0;
        if (exp_mosi_q.size() == 0) chk("mosi_unexpected_byte", int'(s_in), -1);
        else chk("mosi_byte", int'(s_in), int'(exp_mosi_q.pop_front()));
      end
    end
    if (!spi_ss && prev_sck && !spi_sck) begin
      last_fall = cyc;
      s_bit++;
      if (s_bit == 8) begin
        s_bit = 0;
        s_out = pop_slave();
      end
      spi_miso = s_out[7 - s_bit];
    end
    if (rx_valid) begin
      n_rxv++;
      if (exp_rx_q.size() == 0) chk("rx_unexpected", int'(rx_data), -1);
      else chk("rx_data", int'(rx_data), int'(exp_rx_q.pop_front()));
    end
    if (tx_ready) n_txr++;
    if (ack_ok) n_ackok++;
    if (ack_err) n_ackerr++;
    if (ack_ok || ack_err) chk("ack_with_rx_valid", int'(rx_valid), 1);
    prev_sck = spi_sck;
    prev_ss = spi_ss;
  end

  typedef struct packed {
    logic [7:0]      op;
    int              len;
    logic [3:0][7:0] pay;
    logic [3:0][7:0] slv;     // slv[0] is returned during the opcode byte
    int              stall_k; // payload index withheld for a while, -1 none
    int              ack_ok;
    int              ack_err;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] op, input int len,
                              input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                              input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3,
                              input int stall_k, input int aok, input int aerr);
    vec_t v;
    v.op = op; v.len = len;
    v.pay[0] = p0; v.pay[1] = p1; v.pay[2] = p2; v.pay[3] = 8'h00;
    v.slv[0] = s0; v.slv[1] = s1; v.slv[2] = s2; v.slv[3] = s3;
    v.stall_k = stall_k; v.ack_ok = aok; v.ack_err = aerr;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input int abort_rise);
    int k = 0, hold = 0, guard = 0;
    int b_rise = n_rise, b_rxv = n_rxv, b_txr = n_txr, b_aok = n_ackok, b_aerr = n_ackerr;
    int busy_fall = 0;
    bit took = 1'b0, done = 1'b0;
    exp_mosi_q.push_back(v.op);
    for (int i = 0; i < v.len; i++) begin
      exp_mosi_q.push_back(v.pay[i]);
      exp_rx_q.push_back(v.slv[i + 1]);
    end
    for (int i = 0; i <= v.len; i++) slave_q.push_back(v.slv[i]);

    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = v.op; cmd_len = 16'(v.len);
    tx_data = v.pay[0];
    if (v.len > 0 && v.stall_k == 0) begin tx_valid = 1'b0; hold = STALL_N; end
    else tx_valid = (v.len > 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    chk("cmd_ready_after_accept", int'(cmd_ready), 0);

    while (guard < 3000) begin
      guard++;
      @(negedge clk);
      took = tx_ready;
      if (hold > 0 && hold <= 8) begin
        chk("stall_sck_low", int'(spi_sck), 0);
        chk("stall_ss_low", int'(spi_ss), 0);
      end
      if (!busy) begin done = 1'b1; busy_fall = cyc; break; end
      if (abort_rise > 0 && (n_rise - b_rise) >= abort_rise) begin done = 1'b1; break; end
      @(posedge clk); #1;
      if (hold > 0) begin
        hold--;
        if (hold == 0) tx_valid = 1'b1;
      end
      if (took) begin
        k++;
        tx_data = (k < 4) ? v.pay[k] : 8'h00;
        if (k < v.len) begin
          if (k == v.stall_k) begin tx_valid = 1'b0; hold = STALL_N; end
          else tx_valid = 1'b1;
        end else tx_valid = 1'b0;
      end
    end
    if (!done) chk("timeout_waiting_busy_low", 1, 0);
    if (abort_rise == 0) begin
      chk("tx_ready_count", n_txr - b_txr, v.len);
      chk("rx_valid_count", n_rxv - b_rxv, v.len);
      chk("sck_rise_count", n_rise - b_rise, 8 * (1 + v.len));
      chk("mosi_queue_left", exp_mosi_q.size(), 0);
      chk("rx_queue_left", exp_rx_q.size(), 0);
      chk("ack_ok_count", n_ackok - b_aok, v.ack_ok);
      chk("ack_err_count", n_ackerr - b_aerr, v.ack_err);
      chk("cmd_ready_at_idle", int'(cmd_ready), 1);
      chk("ss_high_at_idle", int'(spi_ss), 1);
      chk("setup_latency", first_rise - ss_fall_cyc, SS_SETUP + CLK_DIV);
      chk("hold_before_ss_rise", ss_rise_cyc - last_fall, CLK_DIV);
      chk("gap_length", busy_fall - ss_rise_cyc, SS_GAP);
      if (v.stall_k < 0)
        chk("sck_span_contiguous", last_fall - first_rise, (16 * (1 + v.len) - 1) * CLK_DIV);
      $display("txn op=%02h len=%0d tx_ready=%0d rx_valid=%0d sck_rises=%0d",
               v.op, v.len, n_txr - b_txr, n_rxv - b_rxv, n_rise - b_rise);
    end
  endtask

  vec_t tbl[8];

  initial begin
    int base_rxv;
    tbl[0] = mk(OP_OSDEN,   0, 8'h00, 8'h00, 8'h00, 8'hC3, 8'h00, 8'h00, 8'h00, -1, 0, 0);
    tbl[1] = mk(OP_OSDWR,   2, 8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h11, 8'h22, 8'h00, -1, 0, 0);
    tbl[2] = mk(OP_RDDATA,  1, 8'h00, 8'h00, 8'h00, 8'hC3, 8'h5A, 8'h00, 8'h00, -1, 0, 0);
    tbl[3] = mk(OP_PUMP,    3, 8'h12, 8'h34, 8'h56, 8'h00, 8'h81, 8'h7E, 8'hE7,  1, 0, 0);
    tbl[4] = mk(OP_ACK,     1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h4B, 8'h00, 8'h00, -1, ACK_EN, 0);
    tbl[5] = mk(OP_ACK,     1, 8'h00, 8'h00, 8'h00, 8'h4B, 8'h4A, 8'h00, 8'h00, -1, 0, ACK_EN);
    tbl[6] = mk(OP_RDCONF,  1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h4B, 8'h00, 8'h00, -1, 0, 0);
    tbl[7] = mk(OP_OSDDIS,  0, 8'h00, 8'h00, 8'h00, 8'h99, 8'h00, 8'h00, 8'h00, -1, 0, 0);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_ss", int'(spi_ss), 1);
    chk("reset_sck", int'(spi_sck), 0);
    chk("reset_mosi", int'(spi_mosi), 0);
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_tx_ready", int'(tx_ready), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_ack_ok", int'(ack_ok), 0);
    chk("reset_ack_err", int'(ack_err), 0);

    for (int i = 0; i < 7; i++) run_txn(tbl[i], 0);

    // Abort: reset during bit 5 of payload byte 1
    base_rxv = n_rxv;
    run_txn(mk(OP_RDDATA, 2, 8'h00, 8'h00, 8'h00, 8'hC3, 8'h5A, 8'hA5, 8'h00, -1, 0, 0), 13);
    @(posedge clk); #1;
    reset = 1'b1;
    tx_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_ss", int'(spi_ss), 1);
    chk("abort_sck", int'(spi_sck), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rx_valid", int'(rx_valid), 0);
    chk("abort_cmd_ready", int'(cmd_ready), 1);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_rx_valid", n_rxv - base_rxv, 0);
    $display("txn abort op=%02h rx_valid=%0d", OP_RDDATA, n_rxv - base_rxv);
    exp_mosi_q.delete();
    exp_rx_q.delete();
    slave_q.delete();

    run_txn(tbl[7], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
